// File: rtl/score_pkg.sv
// Shared types and constants for the score accumulator and its binary-to-BCD engine.
package score_pkg;

  localparam int unsigned BIN_W     = 27;
  localparam int unsigned DIGITS    = 8;
  localparam int unsigned BCD_W     = 4 * DIGITS;
  localparam int unsigned SHR_W     = BCD_W + BIN_W;
  localparam int unsigned CNT_W     = $clog2(BIN_W);
  localparam int unsigned MAX_SCORE = 99999999;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/bcd_adjust.sv
// Double-dabble correction step: adds 3 to every BCD nibble that is 5 or more.
module bcd_adjust
  import score_pkg::*;
(
  input  logic [BCD_W-1:0] bcd,
  output logic [BCD_W-1:0] adj_c
);

  always_comb begin
    adj_c = bcd;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        adj_c[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
  end

endmodule

// File: rtl/score_bcd_accum.sv
// Saturating point accumulator with a multi-cycle double-dabble converter feeding
// the seven-segment display stage with packed BCD.
module score_bcd_accum
  import score_pkg::*;
#(
  parameter int unsigned VAL_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             add_valid,
  input  logic [VAL_W-1:0] add_value,
  input  logic             clear,
  output logic [BCD_W-1:0] bcd_out,
  output logic             bcd_valid,
  output logic             updated,
  output logic             busy,
  output logic             saturated
);

  state_t             state_q, state_nxt;
  logic [BIN_W-1:0]   accum_q, accum_nxt;
  logic               dirty_q, dirty_nxt;
  logic [SHR_W-1:0]   shreg_q, shreg_nxt;
  logic [CNT_W-1:0]   cnt_q, cnt_nxt;
  logic [BCD_W-1:0]   bcd_nxt;
  logic               valid_nxt;
  logic               updated_nxt;
  logic               busy_nxt;
  logic               sat_nxt;
  logic [BIN_W:0]     sum_c;
  logic [BCD_W-1:0]   adj_c;

  bcd_adjust u_adjust (
    .bcd   (shreg_q[SHR_W-1 -: BCD_W]),
    .adj_c (adj_c)
  );

  assign sum_c = {1'b0, accum_q} + (BIN_W+1)'(add_value);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      accum_q   <= '0;
      dirty_q   <= 1'b0;
      shreg_q   <= '0;
      cnt_q     <= '0;
      bcd_out   <= '0;
      bcd_valid <= 1'b0;
      updated   <= 1'b0;
      busy      <= 1'b0;
      saturated <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      accum_q   <= accum_nxt;
      dirty_q   <= dirty_nxt;
      shreg_q   <= shreg_nxt;
      cnt_q     <= cnt_nxt;
      bcd_out   <= bcd_nxt;
      bcd_valid <= valid_nxt;
      updated   <= updated_nxt;
      busy      <= busy_nxt;
      saturated <= sat_nxt;
    end
  end

  always_comb begin
    state_nxt   = state_q;
    accum_nxt   = accum_q;
    dirty_nxt   = dirty_q;
    shreg_nxt   = shreg_q;
    cnt_nxt     = cnt_q;
    bcd_nxt     = bcd_out;
    valid_nxt   = bcd_valid;
    updated_nxt = 1'b0;
    sat_nxt     = saturated;

    unique case (state_q)
      // An event arriving this cycle also starts LOAD, so the snapshot is taken on the next edge.
      IDLE: begin
        if (dirty_q || add_valid || clear) begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        shreg_nxt = {BCD_W'(0), accum_q};
        dirty_nxt = 1'b0;
        cnt_nxt   = '0;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        shreg_nxt = {adj_c, shreg_q[BIN_W-1:0]} << 1;
        cnt_nxt   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        bcd_nxt     = shreg_q[SHR_W-1 -: BCD_W];
        valid_nxt   = 1'b1;
        updated_nxt = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // Score events come after the FSM so a same-cycle event keeps dirty set over LOAD.
    if (clear) begin
      accum_nxt = '0;
      sat_nxt   = 1'b0;
      dirty_nxt = 1'b1;
    end else if (add_valid) begin
      if (sum_c > (BIN_W+1)'(MAX_SCORE)) begin
        accum_nxt = BIN_W'(MAX_SCORE);
        sat_nxt   = 1'b1;
      end else begin
        accum_nxt = sum_c[BIN_W-1:0];
      end
      dirty_nxt = 1'b1;
    end

    busy_nxt = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_score_bcd_accum.sv
// Scoreboard bench for score_bcd_accum: a decimal-arithmetic score model feeds
// a queue of pending scores that an independent monitor matches on each update.
module tb_score_bcd_accum;

  localparam longint MAX = 99999999;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        add_valid = 1'b0;
  logic [15:0] add_value = '0;
  logic        clear = 1'b0;
  logic [31:0] bcd_out;
  logic        bcd_valid;
  logic        updated;
  logic        busy;
  logic        saturated;

  int          n_tests = 0;
  int          n_fail = 0;
  int unsigned cyc = 0;

  longint      model_acc = 0;
  bit          model_sat = 1'b0;
  longint      hist[$];
  longint      upd_log[$];
  int unsigned upd_cyc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  score_bcd_accum #(.VAL_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .add_valid (add_valid),
    .add_value (add_value),
    .clear     (clear),
    .bcd_out   (bcd_out),
    .bcd_valid (bcd_valid),
    .updated   (updated),
    .busy      (busy),
    .saturated (saturated)
  );

  function automatic logic [31:0] to_bcd(input longint v);
    logic [31:0] r;
    longint      x;
    r = '0;
    x = v;
    for (int k = 0; k < 8; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic longint to_dec(input logic [31:0] b, output bit ok);
    longint v;
    logic [3:0] nib;
    v  = 0;
    ok = 1'b1;
    for (int k = 7; k >= 0; k--) begin
      nib = b[4*k +: 4];
      if (nib > 4'd9) ok = 1'b0;
      v = v * 10 + longint'(nib);
    end
    return v;
  endfunction

  task automatic check(input string name, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  // Monitor: every update must show a valid BCD number equal to some pending snapshot, in order.
  initial begin
    longint v;
    bit     ok;
    bit     found;
    forever begin
      @(negedge clk);
      if (rst_n && updated) begin
        v = to_dec(bcd_out, ok);
        upd_log.push_back(v);
        upd_cyc.push_back(cyc);
        check("update_digits_valid", longint'(ok), 1);
        while (hist.size() > 0 && hist[0] != v) void'(hist.pop_front());
        found = (hist.size() != 0);
        n_tests++;
        if (!found) begin
          n_fail++;
          $display("FAIL update_snapshot: got %0d, not among pending scores (latest %0d)", v, model_acc);
          hist.push_back(model_acc);
        end
      end
    end
  end

  task automatic ev(input bit a, input int v, input bit c);
    @(negedge clk);
    add_valid = a;
    add_value = 16'(v);
    clear     = c;
    if (c) begin
      model_acc = 0;
      model_sat = 1'b0;
    end else if (a) begin
      model_acc = model_acc + longint'(v);
      if (model_acc > MAX) begin
        model_acc = MAX;
        model_sat = 1'b1;
      end
    end
    if (a || c) hist.push_back(model_acc);
  endtask

  task automatic drop();
    @(negedge clk);
    add_valid = 1'b0;
    clear     = 1'b0;
  endtask

  task automatic settle();
    int quiet;
    int n;
    quiet = 0;
    n = 0;
    while (quiet < 4 && n < 600) begin
      @(negedge clk);
      n++;
      if (busy) quiet = 0;
      else quiet++;
    end
    n_tests++;
    if (quiet < 4) begin
      n_fail++;
      $display("FAIL settle_timeout: busy=%0b after %0d cycles, expected 0", busy, n);
    end
  endtask

  task automatic check_final(input string name);
    check({name, "_bcd"}, longint'(bcd_out), longint'(to_bcd(model_acc)));
    check({name, "_sat"}, longint'(saturated), longint'(model_sat));
    check({name, "_busy"}, longint'(busy), 0);
  endtask

  initial begin
    int unsigned add_edge;
    int r;
    int gap;

    // Reset values while held in reset
    repeat (3) @(negedge clk);
    check("rst_bcd", longint'(bcd_out), 0);
    check("rst_valid", longint'(bcd_valid), 0);
    check("rst_updated", longint'(updated), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_sat", longint'(saturated), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single add: 29-cycle latency and value
    upd_log.delete();
    upd_cyc.delete();
    ev(1'b1, 1234, 1'b0);
    add_edge = cyc + 1;
    drop();
    settle();
    check("t1_update_count", longint'(upd_log.size()), 1);
    if (upd_cyc.size() >= 1) check("t1_latency", longint'(upd_cyc[0] - add_edge), 29);
    check("t1_bcd", longint'(bcd_out), 64'h1234);
    check("t1_valid", longint'(bcd_valid), 1);
    check("t1_busy", longint'(busy), 0);

    // Saturation then clear
    ev(1'b0, 0, 1'b1);
    drop();
    settle();
    for (int i = 0; i < 1526; i++) ev(1'b1, 65535, 1'b0);
    drop();
    settle();
    check("t2_sat_bcd", longint'(bcd_out), 64'h99999999);
    check("t2_sat_flag", longint'(saturated), 1);
    check_final("t2");
    ev(1'b0, 0, 1'b1);
    drop();
    settle();
    check("t2_clear_bcd", longint'(bcd_out), 0);
    check("t2_clear_sat", longint'(saturated), 0);

    // Add during a conversion: exactly two updates, 5 then 12
    upd_log.delete();
    ev(1'b1, 5, 1'b0);
    drop();
    repeat (8) @(negedge clk);
    check("t3_busy_mid", longint'(busy), 1);
    ev(1'b1, 7, 1'b0);
    drop();
    settle();
    check("t3_update_count", longint'(upd_log.size()), 2);
    if (upd_log.size() >= 2) begin
      check("t3_first", upd_log[0], 5);
      check("t3_second", upd_log[1], 12);
    end
    check("t3_bcd", longint'(bcd_out), 64'h12);

    // Clear wins over a simultaneous add
    ev(1'b0, 0, 1'b1);
    ev(1'b1, 100, 1'b0);
    drop();
    settle();
    check("t4_pre_bcd", longint'(bcd_out), 64'h100);
    ev(1'b1, 50, 1'b1);
    drop();
    settle();
    check("t4_bcd", longint'(bcd_out), 0);
    check_final("t4");

    // Reset in the middle of SHIFT
    ev(1'b1, 999, 1'b0);
    drop();
    settle();
    check("t5_pre_bcd", longint'(bcd_out), 64'h999);
    ev(1'b1, 1, 1'b0);
    drop();
    repeat (10) @(negedge clk);
    check("t5_busy_mid", longint'(busy), 1);
    rst_n = 1'b0;
    model_acc = 0;
    model_sat = 1'b0;
    hist.delete();
    #1;
    check("t5_rst_bcd", longint'(bcd_out), 0);
    check("t5_rst_valid", longint'(bcd_valid), 0);
    check("t5_rst_busy", longint'(busy), 0);
    check("t5_rst_updated", longint'(updated), 0);
    @(negedge clk);
    rst_n = 1'b1;
    upd_log.delete();
    repeat (40) @(negedge clk);
    check("t5_no_update", longint'(upd_log.size()), 0);
    check("t5_idle_busy", longint'(busy), 0);
    ev(1'b1, 1, 1'b0);
    drop();
    settle();
    check("t5_bcd", longint'(bcd_out), 64'h1);

    // Random event stream checked by the monitor, then exactly at the end
    for (int i = 0; i < 1000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 3) ev(1'b0, 0, 1'b1);
      else if (r < 5) ev(1'b1, int'($urandom_range(0, 65535)), 1'b1);
      else if (r < 10) ev(1'b1, 65535, 1'b0);
      else ev(1'b1, int'($urandom_range(0, 65535)), 1'b0);
      if ($urandom_range(0, 3) == 0) begin
        drop();
        gap = int'($urandom_range(0, 40));
        repeat (gap) @(negedge clk);
      end
    end
    drop();
    settle();
    check_final("t6");
    check("t6_valid", longint'(bcd_valid), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/score_bcd_accum.md
Name: score_bcd_accum

Overview:
Upstream feeder for the seven-segment score display stage. Accumulates game point events into a saturating binary score. A multi-cycle double-dabble engine converts the score to 8-digit packed BCD, so the display stage shows decimal digits rather than hex. The display stage's 32-bit score input connects directly to bcd_out.

Parameters:
VAL_W, 16, width of one point increment
BIN_W, 27, accumulator width (enough for 99_999_999)
MAX_SCORE, 99999999, saturation ceiling
DIGITS, 8, BCD digits in bcd_out (4 bits each)

Ports:
clk  in  1  system clock, all logic rising-edge
rst_n  in  1  asynchronous, active-low reset
add_valid  in  1  one-cycle strobe: add add_value to score
add_value  in  VAL_W  unsigned increment, sampled when add_valid=1
clear  in  1  one-cycle strobe: score to 0
bcd_out  out  4*DIGITS  packed BCD score, digit 0 in bits [3:0]
bcd_valid  out  1  high once the first conversion has completed
updated  out  1  one-cycle pulse when bcd_out changes
busy  out  1  conversion in progress (state not IDLE)
saturated  out  1  sticky: score reached MAX_SCORE by clamping

Behaviour:
- Reset (rst_n=0, async): accum=0, bcd_out=0, bcd_valid=0, updated=0, busy=0, saturated=0, dirty=0, state=IDLE.
- Accumulate on a clk edge with add_valid=1 and clear=0:
  - accum <= min(accum+add_value, MAX_SCORE); sum computed at BIN_W+1 bits.
  - saturated <= 1 if the clamp was applied.
  - dirty <= 1.
  - add_value=0 still sets dirty.
- Clear on a clk edge with clear=1: accum<=0, saturated<=0, dirty<=1. clear and add_valid in the same cycle: clear wins, the add is dropped.
- Add/clear are accepted every cycle, including while busy; never stalled or lost (except an add coinciding with clear).
- FSM states IDLE, LOAD, SHIFT, DONE:
  - IDLE: dirty=1 -> LOAD.
  - LOAD: shift reg <= {zero BCD field, accum}, dirty <= 0 (unless a new add/clear arrives this same cycle; the new event wins), cnt <= 0 -> SHIFT.
  - SHIFT: each cycle, first add 3 to every BCD nibble >= 5, then shift the whole register left 1, cnt++. After BIN_W shifts -> DONE.
  - DONE: bcd_out <= BCD field, bcd_valid <= 1, updated <= 1 for exactly this one cycle -> IDLE.
- Latency from an add sampled at edge E0, FSM idle: LOAD at E1, shifts at E2..E(BIN_W+1), bcd_out updated at edge E(BIN_W+2) = 29 cycles.
- Events during a conversion set dirty. The current conversion completes with the snapshot value, then IDLE -> LOAD re-converts the latest accum. Intermediate values may be skipped; the final bcd_out always equals the final accum.
- bcd_out holds its value between conversions. It never shows a partially converted value.
- busy=1 in LOAD, SHIFT and DONE.
- bcd_valid stays 1 until reset.
- Reset asserted mid-conversion aborts immediately to the reset values.

Decomposition:
- Shared package score_pkg:
  - state enum (IDLE, LOAD, SHIFT, DONE)
  - MAX_SCORE, DIGITS and BIN_W constants
  - BCD field width 4*DIGITS
- Sub-module bcd_adjust: combinational, 4*DIGITS in/out, applies "+3 if nibble >= 5" to every nibble. Instantiated once in the SHIFT datapath.

Test Plan:
- Reset release, then one add_valid with add_value=1234 -> updated pulses 29 cycles later; bcd_out=32'h00001234, bcd_valid=1, busy low after.
- Adds of 65535 repeated 1526 times -> final bcd_out=32'h99999999, saturated=1. A following clear -> bcd_out=32'h00000000, saturated=0.
- add 5 then, 10 cycles later (busy), add 7 -> first updated shows 32'h00000005, second updated shows 32'h00000012, no further updates.
- clear and add_valid (add_value=50) in the same cycle on score 100 -> bcd_out=32'h00000000.
- rst_n pulsed low mid-SHIFT after score 999 -> all outputs 0 immediately, no updated pulse. A following add 1 -> bcd_out=32'h00000001.
- Random add sequence (1000 events, random values/gaps) -> each updated bcd_out decodes to min(running sum, 99999999) at its snapshot; the final value matches exactly.
